// File: rtl/as1802_uart.sv
// rtl/as1802_uart.sv - AS1802 bus UART, 8N1; AS1802_UART_FIFO_EN selects DEPTH-entry FIFOs over single holding registers
module as1802_uart_fifo #(
  parameter int D = 4
) (
  input  logic       xclk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D) + 1;
  localparam logic [AW-1:0] LAST     = AW'(D - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(D);

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  assign rdata   = mem[rptr];
  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage write; entries are qualified by cnt so they need no reset
  always_ff @(posedge xclk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  // Pointers wrap at D-1; a push and pop together leave occupancy unchanged
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (pop_ok)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module as1802_uart #(
  parameter int         DIV       = 104,
  parameter logic [2:0] TX_PORT   = 3'd1,
  parameter logic [2:0] RX_PORT   = 3'd1,
  parameter logic [2:0] STAT_PORT = 3'd2,
  parameter int         DEPTH     = 4
) (
  input  logic       xclk,
  input  logic       rst_n,
  input  logic [2:0] N,
  input  logic       MRD_b,
  input  logic       MWR_b,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  output logic       D_oe,
  output logic [1:0] EF_b,
  output logic       int_b,
  input  logic       RXD,
  output logic       TXD
);
`ifdef AS1802_UART_FIFO_EN
  localparam int FD = DEPTH;
`else
  // Single holding register per direction; DEPTH has no effect here
  localparam int FD = (DEPTH > 0) ? 1 : 1;
`endif
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // Bus decode: MRD_b low means OUT (CPU writes us), MWR_b low means INP
  logic tx_wr_stb, ctl_wr_stb, rx_rd_stb, st_rd_stb;
  logic tx_wr_q, ctl_wr_q, rx_rd_q, st_rd_q;
  logic [7:0] d_reg;
  logic tx_commit, ctl_commit, rx_rd_done, st_rd_done;

  assign tx_wr_stb  = (N != 3'd0) && (N == TX_PORT)   && !MRD_b;
  assign ctl_wr_stb = (N != 3'd0) && (N == STAT_PORT) && !MRD_b;
  assign rx_rd_stb  = (N != 3'd0) && (N == RX_PORT)   && !MWR_b;
  assign st_rd_stb  = (N != 3'd0) && (N == STAT_PORT) && !MWR_b;

  assign tx_commit  = tx_wr_q  && !tx_wr_stb;
  assign ctl_commit = ctl_wr_q && !ctl_wr_stb;
  assign rx_rd_done = rx_rd_q  && !rx_rd_stb;
  assign st_rd_done = st_rd_q  && !st_rd_stb;

  // FIFO interconnect
  logic       tx_pop, tx_empty, tx_full;
  logic [7:0] tx_head;
  logic       rx_push, rx_empty, rx_full, rx_avail;
  logic [7:0] rx_head;

  // Flags
  logic int_en, overrun, frame_err, rx_set_ovr, rx_set_ferr;
  logic [7:0] status;

  // TX datapath
  uart_state_t tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic        txd_n;

  // RX datapath
  uart_state_t rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic        rxd_s1, rxd_s2, rxd_s3;

  as1802_uart_fifo #(.D(FD)) u_tx_fifo (
    .xclk(xclk), .rst_n(rst_n), .push(tx_commit), .pop(tx_pop),
    .wdata(d_reg), .rdata(tx_head), .empty(tx_empty), .full(tx_full)
  );

  as1802_uart_fifo #(.D(FD)) u_rx_fifo (
    .xclk(xclk), .rst_n(rst_n), .push(rx_push), .pop(rx_rd_done),
    .wdata(rx_sh), .rdata(rx_head), .empty(rx_empty), .full(rx_full)
  );

  assign rx_avail = !rx_empty;
  assign status   = {4'b0000, overrun, frame_err, tx_full, rx_avail};
  assign EF_b     = {!tx_full, !rx_avail};
  assign D_oe     = rx_rd_stb || st_rd_stb;

  // Read mux: empty RX reads return zero
  always_comb begin
    D_out = 8'h00;
    if (rx_rd_stb && rx_avail) D_out = rx_head;
    else if (st_rd_stb)        D_out = status;
  end

  // Capture write data while strobed and remember strobes for edge detection
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg    <= 8'h00;
      tx_wr_q  <= 1'b0;
      ctl_wr_q <= 1'b0;
      rx_rd_q  <= 1'b0;
      st_rd_q  <= 1'b0;
    end else begin
      if (tx_wr_stb || ctl_wr_stb) d_reg <= D_in;
      tx_wr_q  <= tx_wr_stb;
      ctl_wr_q <= ctl_wr_stb;
      rx_rd_q  <= rx_rd_stb;
      st_rd_q  <= st_rd_stb;
    end
  end

  // Control/status flags; a new error in the clearing cycle is kept
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      int_en    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      int_b     <= 1'b1;
    end else begin
      if (ctl_commit) int_en <= d_reg[0];
      if (st_rd_done) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rx_set_ovr)  overrun   <= 1'b1;
      if (rx_set_ferr) frame_err <= 1'b1;
      int_b <= !(int_en && rx_avail);
    end
  end

  // TX state register; TXD is a flop so reset drives it high at once
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      TXD      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      TXD      <= txd_n;
    end
  end

  // TX next state: every bit lasts DIV cycles; STOP chains into START when more data waits
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 16'd1;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    txd_n      = TXD;
    tx_pop     = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_n = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_n    = tx_head;
          txd_n      = 1'b0;
          tx_state_n = S_START;
        end
      end
      S_START: begin
        if (tx_cnt == DIV_M1) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          txd_n      = tx_sh[0];
          tx_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_cnt == DIV_M1) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            txd_n      = 1'b1;
            tx_state_n = S_STOP;
          end else begin
            tx_bit_n = tx_bit + 3'd1;
            tx_sh_n  = {1'b0, tx_sh[7:1]};
            txd_n    = tx_sh[1];
          end
        end
      end
      default: begin
        if (tx_cnt == DIV_M1) begin
          tx_cnt_n = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_n    = tx_head;
            txd_n      = 1'b0;
            tx_state_n = S_START;
          end else begin
            tx_state_n = S_IDLE;
          end
        end
      end
    endcase
  end

  // RX synchroniser plus one extra stage for falling-edge detection, then state register
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_s3   <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rxd_s1   <= RXD;
      rxd_s2   <= rxd_s1;
      rxd_s3   <= rxd_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
    end
  end

  // RX next state: half-bit start check rejects glitches, then DIV-spaced samples
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt + 16'd1;
    rx_bit_n    = rx_bit;
    rx_sh_n     = rx_sh;
    rx_push     = 1'b0;
    rx_set_ovr  = 1'b0;
    rx_set_ferr = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_n = '0;
        if (rxd_s3 && !rxd_s2) rx_state_n = S_START;
      end
      S_START: begin
        if (rx_cnt == HALF_M1) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rxd_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt == DIV_M1) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rxd_s2, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state_n = S_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      default: begin
        if (rx_cnt == DIV_M1) begin
          rx_cnt_n   = '0;
          rx_state_n = S_IDLE;
          if (!rxd_s2)      rx_set_ferr = 1'b1;
          else if (rx_full) rx_set_ovr  = 1'b1;
          else              rx_push     = 1'b1;
        end
      end
    endcase
  end
endmodule
